sketch_row_counter: RTL and testbench

SKETCH_ROW_COUNTER -- requirements
Module: sketch_row_counter

---
 rtl/sketch_row_counter.sv | 182 ++++++++++++++++++
 tb/tb_sketch_row_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sketch_row_counter.sv
// One row of a count-min sketch: DEPTH saturating counters with a 2-stage
// read-modify-write update path, a fixed-latency query path and a full-row clear sweep.
module sketch_row_counter #(
    parameter int HASH_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid_i,
    input  logic [HASH_WIDTH-1:0] upd_idx_i,
    input  logic                  qry_valid_i,
    input  logic [HASH_WIDTH-1:0] qry_idx_i,
    input  logic                  clr_i,
    output logic                  qry_valid_o,
    output logic [CNT_WIDTH-1:0]  qry_cnt_o,
    output logic                  busy_o
);

    localparam int DEPTH = 1 << HASH_WIDTH;
    localparam logic [HASH_WIDTH-1:0] LAST_PTR = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [HASH_WIDTH-1:0]   ptr_reg;
    logic [HASH_WIDTH-1:0]   ptr_next;

    logic                    run;
    logic                    clr_take;
    logic                    upd_take;
    logic                    qry_take;

    // Counter storage: one write port, registered reads; contents are never reset,
    // the clear sweep is what zeroes them.
    logic [CNT_WIDTH-1:0]    mem [DEPTH];
    logic [CNT_WIDTH-1:0]    upd_rd_reg;
    logic [CNT_WIDTH-1:0]    qry_rd_reg;

    logic                    ram_we;
    logic [HASH_WIDTH-1:0]   ram_waddr;
    logic [CNT_WIDTH-1:0]    ram_wdata;

    // Update write stage
    logic                    s1_valid_reg;
    logic [HASH_WIDTH-1:0]   s1_idx_reg;
    logic                    s1_fwd_hit_reg;
    logic [CNT_WIDTH-1:0]    s1_fwd_val_reg;
    logic [CNT_WIDTH-1:0]    upd_old;
    logic [CNT_WIDTH-1:0]    upd_new;

    // Query stages
    logic                    q1_valid_reg;
    logic                    q1_fwd_hit_reg;
    logic [CNT_WIDTH-1:0]    q1_fwd_val_reg;
    logic [CNT_WIDTH-1:0]    q1_value;
    logic                    qry_valid_reg;
    logic [CNT_WIDTH-1:0]    qry_cnt_reg;

    assign run      = (state_reg == ST_RUN);
    assign clr_take = run & clr_i;
    assign upd_take = run & upd_valid_i & ~clr_i;
    assign qry_take = run & qry_valid_i & ~clr_i;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (ptr_reg == LAST_PTR) begin
                    state_next = ST_RUN;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_i) begin
                    state_next = ST_CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign busy_o = rst | (state_reg == ST_CLEAR);

    // ------------------------------------------------------------------
    // Counter RAM
    // ------------------------------------------------------------------
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s1_idx_reg;
        ram_wdata = upd_new;
        if (state_reg == ST_CLEAR) begin
            ram_we    = ~rst;
            ram_waddr = ptr_reg;
            ram_wdata = '0;
        end else if (s1_valid_reg) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        upd_rd_reg <= mem[upd_idx_i];
        qry_rd_reg <= mem[qry_idx_i];
    end

    // ------------------------------------------------------------------
    // Update path: the RAM read issued alongside the previous update's write
    // returns stale data, so that write's value is captured and substituted.
    // ------------------------------------------------------------------
    assign upd_old = s1_fwd_hit_reg ? s1_fwd_val_reg : upd_rd_reg;
    assign upd_new = (upd_old == CNT_MAX) ? upd_old : upd_old + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_idx_reg     <= '0;
            s1_fwd_hit_reg <= 1'b0;
            s1_fwd_val_reg <= '0;
        end else begin
            s1_valid_reg   <= upd_take;
            s1_idx_reg     <= upd_idx_i;
            s1_fwd_hit_reg <= s1_valid_reg && (s1_idx_reg == upd_idx_i);
            s1_fwd_val_reg <= upd_new;
        end
    end

    // ------------------------------------------------------------------
    // Query path: same forwarding trick, so an update accepted the cycle
    // before the query is visible while one in the same cycle is not.
    // ------------------------------------------------------------------
    assign q1_value = q1_fwd_hit_reg ? q1_fwd_val_reg : qry_rd_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_valid_reg   <= 1'b0;
            q1_fwd_hit_reg <= 1'b0;
            q1_fwd_val_reg <= '0;
            qry_valid_reg  <= 1'b0;
            qry_cnt_reg    <= '0;
        end else begin
            q1_valid_reg   <= qry_take;
            q1_fwd_hit_reg <= s1_valid_reg && (s1_idx_reg == qry_idx_i);
            q1_fwd_val_reg <= upd_new;
            // A clear accepted while a query sits in stage 1 kills its result.
            qry_valid_reg  <= q1_valid_reg & ~clr_take;
            if (q1_valid_reg && !clr_take) begin
                qry_cnt_reg <= q1_value;
            end
        end
    end

    assign qry_valid_o = qry_valid_reg;
    assign qry_cnt_o   = qry_cnt_reg;

endmodule

// File: tb/tb_sketch_row_counter.sv
// Directed bench for sketch_row_counter with HASH_WIDTH=4, CNT_WIDTH=4.
module tb_sketch_row_counter;

    logic       clk;
    logic       rst;
    logic       upd_valid_i;
    logic [3:0] upd_idx_i;
    logic       qry_valid_i;
    logic [3:0] qry_idx_i;
    logic       clr_i;
    logic       qry_valid_o;
    logic [3:0] qry_cnt_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    sketch_row_counter #(.HASH_WIDTH(4), .CNT_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_valid_i (upd_valid_i),
        .upd_idx_i   (upd_idx_i),
        .qry_valid_i (qry_valid_i),
        .qry_idx_i   (qry_idx_i),
        .clr_i       (clr_i),
        .qry_valid_o (qry_valid_o),
        .qry_cnt_o   (qry_cnt_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one query, confirm nothing at T+1 and the expected count at T+2.
    task automatic query(input logic [3:0] idx, input int exp, input string tag);
        qry_valid_i = 1'b1;
        qry_idx_i   = idx;
        step();
        qry_valid_i = 1'b0;
        check({tag, "_early_valid"}, 32'(qry_valid_o), 0);
        step();
        check({tag, "_valid"}, 32'(qry_valid_o), 1);
        check({tag, "_cnt"}, 32'(qry_cnt_o), 32'(exp));
    endtask

    task automatic upd(input logic [3:0] idx, input int gap);
        upd_valid_i = 1'b1;
        upd_idx_i   = idx;
        step();
        upd_valid_i = 1'b0;
        repeat (gap) step();
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (busy_o && n < 100) begin
            n++;
            step();
        end
        check(tag, 32'(n), 16);
    endtask

    initial begin
        int n;
        int qv_seen;

        rst         = 1'b1;
        upd_valid_i = 1'b0;
        upd_idx_i   = '0;
        qry_valid_i = 1'b0;
        qry_idx_i   = '0;
        clr_i       = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_busy", 32'(busy_o), 1);
        check("rst_qry_valid", 32'(qry_valid_o), 0);
        check("rst_qry_cnt", 32'(qry_cnt_o), 0);
        rst = 1'b0;
        count_busy("init_sweep_len");
        check("init_busy_low", 32'(busy_o), 0);

        // Every counter reads zero after the initial sweep
        for (int i = 0; i < 16; i++) begin
            query(4'(i), 0, $sformatf("init_q%0d", i));
        end

        // Seven back-to-back increments of index 5
        upd_valid_i = 1'b1;
        upd_idx_i   = 4'd5;
        repeat (7) step();
        upd_valid_i = 1'b0;
        query(4'd5, 7, "b2b_idx5");
        query(4'd4, 0, "b2b_idx4");

        // Twenty increments of index 3 with mixed spacing saturate at 15
        for (int i = 0; i < 20; i++) begin
            upd(4'd3, i % 3);
        end
        query(4'd3, 15, "sat_idx3");
        query(4'd5, 7, "sat_idx5_kept");

        // Same-cycle update and query of index 9 (prior count 2)
        upd(4'd9, 1);
        upd(4'd9, 0);
        upd_valid_i = 1'b1;
        upd_idx_i   = 4'd9;
        qry_valid_i = 1'b1;
        qry_idx_i   = 4'd9;
        step();
        upd_valid_i = 1'b0;
        step();
        qry_valid_i = 1'b0;
        check("same_cycle_valid", 32'(qry_valid_o), 1);
        check("same_cycle_cnt", 32'(qry_cnt_o), 2);
        step();
        check("next_cycle_valid", 32'(qry_valid_o), 1);
        check("next_cycle_cnt", 32'(qry_cnt_o), 3);
        step();
        check("idle_valid", 32'(qry_valid_o), 0);

        // Clear with a query in flight
        qry_valid_i = 1'b1;
        qry_idx_i   = 4'd5;
        step();
        qry_valid_i = 1'b0;
        clr_i       = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr_drop_valid", 32'(qry_valid_o), 0);
        check("clr_busy", 32'(busy_o), 1);
        upd_valid_i = 1'b1;
        upd_idx_i   = 4'd5;
        qry_valid_i = 1'b1;
        qry_idx_i   = 4'd5;
        n       = 0;
        qv_seen = 0;
        while (busy_o && n < 100) begin
            if (qry_valid_o) qv_seen++;
            clr_i = (n == 3);
            n++;
            step();
        end
        upd_valid_i = 1'b0;
        qry_valid_i = 1'b0;
        clr_i       = 1'b0;
        check("clr_sweep_len", 32'(n), 16);
        check("clr_no_qry_valid", 32'(qv_seen), 0);
        step();
        check("clr_post_idle_valid", 32'(qry_valid_o), 0);
        for (int i = 0; i < 16; i++) begin
            query(4'(i), 0, $sformatf("clr_q%0d", i));
        end

        // Reset in the middle of a sweep restarts it from scratch
        upd(4'd5, 0);
        upd(4'd5, 0);
        query(4'd5, 2, "pre_rst_idx5");
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        repeat (8) step();
        check("mid_sweep_busy", 32'(busy_o), 1);
        rst = 1'b1;
        step();
        step();
        check("mid_rst_busy", 32'(busy_o), 1);
        check("mid_rst_qry_valid", 32'(qry_valid_o), 0);
        rst = 1'b0;
        count_busy("restart_sweep_len");
        query(4'd5, 0, "restart_idx5");
        upd(4'd7, 0);
        query(4'd7, 1, "restart_idx7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
